// File: rtl/exe_task_buffer.sv
// Capture buffer for multi-word microcode sequences (TSS images, call frames, descriptor pairs).
// Newest data sits at bit 0; a registered half-word-indexed window reads any WORD_W slice.
module exe_task_buffer #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(2*DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              push_half,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [IDX_W:0]    level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              proto_err
);

  localparam int H       = WORD_W / 2;
  localparam int STORE_W = DEPTH * WORD_W;
  localparam int HCAP    = 2 * DEPTH;

  localparam logic [IDX_W:0]   HCAP_L   = (IDX_W+1)'(HCAP);
  localparam logic [IDX_W+1:0] HCAP_EXT = (IDX_W+2)'(HCAP);
  localparam logic [IDX_W:0]   TWO_L    = (IDX_W+1)'(2);

  logic [STORE_W-1:0] store_q, store_d;
  logic [IDX_W:0]     level_q, level_d;
  logic [WORD_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               proto_err_q, proto_err_d;

  logic [STORE_W-1:0]        popped;
  logic [IDX_W:0]            level_popped;
  logic [1:0]                level_inc;
  logic [IDX_W+1:0]          level_sum;
  logic [STORE_W+WORD_W-1:0] rd_ext;
  logic [31:0]               rd_shift;
  logic [WORD_W-1:0]         rd_window;

  // Zero-extend above the store so windows straddling the top read zeros.
  always_comb begin
    rd_shift  = 32'(rd_index) * 32'(H);
    rd_ext    = {{WORD_W{1'b0}}, store_q} >> rd_shift;
    rd_window = rd_ext[WORD_W-1:0];
  end

  always_comb begin
    store_d      = store_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    proto_err_d  = proto_err_q;
    rd_data_d    = rd_en ? rd_window : rd_data_q;
    rd_valid_d   = rd_en;
    popped       = store_q;
    level_popped = level_q;
    level_inc    = 2'd0;
    level_sum    = '0;

    if (clear) begin
      store_d     = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      proto_err_d = 1'b0;
    end else begin
      // Pop is applied before any push so pop+push replaces the newest word.
      if (pop) begin
        popped       = store_q >> WORD_W;
        level_popped = (level_q < TWO_L) ? '0 : level_q - TWO_L;
        if (level_q < TWO_L) begin
          underflow_d = 1'b1;
        end
      end

      if (push && push_half) begin
        proto_err_d = 1'b1;
      end

      if (push) begin
        store_d   = {popped[STORE_W-WORD_W-1:0], push_data};
        level_inc = 2'd2;
      end else if (push_half) begin
        store_d   = {popped[STORE_W-H-1:0], push_data[H-1:0]};
        level_inc = 2'd1;
      end else begin
        store_d   = popped;
      end

      level_sum = {1'b0, level_popped} + (IDX_W+2)'(level_inc);
      if (level_sum > HCAP_EXT) begin
        overflow_d = 1'b1;
        level_d    = HCAP_L;
      end else begin
        level_d    = level_sum[IDX_W:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      store_q     <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      store_q     <= store_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign level     = level_q;
  assign empty     = (level_q == '0);
  assign full      = (level_q == HCAP_L);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign proto_err = proto_err_q;

endmodule
